// File: rtl/dmux8_seq_pkg.sv
// Shared constants, FSM state type and channel-search helper for dmux8_seq.
package dmux8_seq_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDone
  } state_e;

  // Returns {found, idx}: the lowest set bit of w whose index is >= c.
  // c may equal NUM_CH, in which case nothing is found.
  function automatic logic [SEL_W:0] next_set_ch(input logic [NUM_CH-1:0] w,
                                                 input logic [SEL_W:0]    c);
    logic [SEL_W:0] r;
    r = '0;
    // Descending scan so the lowest qualifying index is the one left in r.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w[i] && (i >= int'(c))) begin
        r = {1'b1, SEL_W'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dmux8_seq_if.sv
// Upstream handshake plus dmux8-facing select/data bus of dmux8_seq.
interface dmux8_seq_if
  import dmux8_seq_pkg::*;
;
  logic              in_valid;
  logic              in_ready;
  logic [NUM_CH-1:0] in_data;
  logic              abort;
  logic [SEL_W-1:0]  s;
  logic              d;
  logic              busy;
  logic              done;

  // Upstream / testbench side.
  modport master (
    output in_valid, in_data, abort,
    input  in_ready, s, d, busy, done
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, abort,
    output in_ready, s, d, busy, done
  );

endinterface

// File: rtl/dmux8_seq_hold_cnt.sv
// Per-channel hold timer: a down-counter reloaded on load or on expiry.
// expire is high during the last cycle a channel is held.
module dmux8_seq_hold_cnt #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned     CntW   = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] Reload = CntW'(HOLD_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == '0);

  // Next count: restart on load or when the current channel's hold ends.
  always_comb begin
    cnt_d = cnt_q;
    if (load || expire) begin
      cnt_d = Reload;
    end else if (en) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmux8_seq.sv
// dmux8_seq: serializes an 8-bit word onto the s/d inputs of a dmux8,
// holding each channel HOLD_CYCLES cycles and ending with a one-cycle done.
// Optional feature macro DMUX8_SEQ_SKIP_ZERO_EN: visit only channels whose
// word bit is set (d=1 throughout); a zero word goes straight to done.
module dmux8_seq
  import dmux8_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input logic         clk,
  input logic         rst,
  dmux8_seq_if.slave  bus
);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] word_q, word_d;
  logic [SEL_W-1:0]  s_q, s_d;
  logic              d_q, d_d;
  logic              done_q, done_d;
  logic              cnt_load;
  logic              expire;

  dmux8_seq_hold_cnt #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .en    (state_q == StDrive),
    .expire(expire)
  );

`ifdef DMUX8_SEQ_SKIP_ZERO_EN
  logic [SEL_W:0] nxt_first;
  logic [SEL_W:0] nxt_after;
  assign nxt_first = next_set_ch(bus.in_data, '0);
  assign nxt_after = next_set_ch(word_q, {1'b0, s_q} + (SEL_W + 1)'(1));
`else
  logic [SEL_W-1:0] s_inc;
  assign s_inc = s_q + SEL_W'(1);
`endif

  // in_ready and busy come straight off the state flops, so they are registered.
  assign bus.in_ready = (state_q == StIdle);
  assign bus.busy     = (state_q != StIdle);
  assign bus.s        = s_q;
  assign bus.d        = d_q;
  assign bus.done     = done_q;

  // FSM next-state and next s/d/done values.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    s_d      = s_q;
    d_d      = d_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          word_d   = bus.in_data;
          cnt_load = 1'b1;
`ifdef DMUX8_SEQ_SKIP_ZERO_EN
          if (nxt_first[SEL_W]) begin
            state_d = StDrive;
            s_d     = nxt_first[SEL_W-1:0];
            d_d     = 1'b1;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
            s_d     = '0;
            d_d     = 1'b0;
          end
`else
          state_d = StDrive;
          s_d     = '0;
          d_d     = bus.in_data[0];
`endif
        end
      end
      StDrive: begin
        // Abort outranks the final expiry, so a late abort still kills done.
        if (bus.abort) begin
          state_d = StIdle;
          s_d     = '0;
          d_d     = 1'b0;
        end else if (expire) begin
`ifdef DMUX8_SEQ_SKIP_ZERO_EN
          if (nxt_after[SEL_W]) begin
            s_d = nxt_after[SEL_W-1:0];
            d_d = 1'b1;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
            s_d     = '0;
            d_d     = 1'b0;
          end
`else
          if (s_q == SEL_W'(NUM_CH - 1)) begin
            state_d = StDone;
            done_d  = 1'b1;
            s_d     = '0;
            d_d     = 1'b0;
          end else begin
            s_d = s_inc;
            d_d = word_q[s_inc];
          end
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
        s_d     = '0;
        d_d     = 1'b0;
      end
      default: begin
        state_d = StIdle;
        s_d     = '0;
        d_d     = 1'b0;
      end
    endcase
  end

  // State, captured word and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      s_q     <= '0;
      d_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      s_q     <= s_d;
      d_q     <= d_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_dmux8_seq.sv
// Self-checking bench for dmux8_seq: two instances (HOLD_CYCLES=2 and 1),
// a table of directed words plus hand-written abort/reset/back-to-back cases.
module tb_dmux8_seq;

`ifdef DMUX8_SEQ_SKIP_ZERO_EN
  localparam bit SkipMode = 1'b1;
`else
  localparam bit SkipMode = 1'b0;
`endif

  localparam logic [6:0] IdleOut = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  dmux8_seq_if bus1 ();
  dmux8_seq_if bus2 ();

  dmux8_seq #(
    .HOLD_CYCLES(1)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1.slave)
  );

  dmux8_seq #(
    .HOLD_CYCLES(2)
  ) u_dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         which;
    int         hold;
    logic [7:0] data;
    int         done_cyc;
  } vec_t;

  vec_t vecs[8];

  // Number of channels a word visits.
  function automatic int n_vis(input logic [7:0] w);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (!SkipMode || w[i]) n++;
    end
    return n;
  endfunction

  // Expected {s, d, done, busy, in_ready} in cycle k after the accept edge.
  function automatic logic [6:0] exp_out(input logic [7:0] w, input int hold, input int k);
    logic [2:0] ch[8];
    logic       dv[8];
    int         n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      ch[i] = 3'd0;
      dv[i] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (!SkipMode || w[i]) begin
        ch[n] = 3'(i);
        dv[n] = SkipMode ? 1'b1 : w[i];
        n++;
      end
    end
    if (k >= 1 && k <= n * hold) return {ch[(k-1)/hold], dv[(k-1)/hold], 1'b0, 1'b1, 1'b0};
    else if (k == n * hold + 1) return 7'b0000110;
    else return IdleOut;
  endfunction

  function automatic logic [6:0] get_out(input int which);
    if (which == 1) return {bus1.s, bus1.d, bus1.done, bus1.busy, bus1.in_ready};
    else return {bus2.s, bus2.d, bus2.done, bus2.busy, bus2.in_ready};
  endfunction

  task automatic set_in(input int which, input logic v, input logic [7:0] data, input logic ab);
    if (which == 1) begin
      bus1.in_valid = v;
      bus1.in_data  = data;
      bus1.abort    = ab;
    end else begin
      bus2.in_valid = v;
      bus2.in_data  = data;
      bus2.abort    = ab;
    end
  endtask

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got s=%0d d=%b done=%b busy=%b ready=%b, want s=%0d d=%b done=%b busy=%b ready=%b",
               name, act[6:4], act[3], act[2], act[1], act[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Present a word for one edge, then scramble in_data to prove it was captured.
  task automatic send(input int which, input logic [7:0] w);
    @(negedge clk);
    set_in(which, 1'b1, w, 1'b0);
    @(posedge clk);
    #1 set_in(which, 1'b0, ~w, 1'b0);
  endtask

  task automatic run_txn(input int which, input int hold, input logic [7:0] w, input int exp_done);
    int         len;
    int         done_at;
    logic [6:0] o;
    len     = n_vis(w) * hold + 2;
    done_at = -1;
    send(which, w);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      o = get_out(which);
      check($sformatf("dut%0d w=%h cyc%0d", which, w, k), o, exp_out(w, hold, k));
      if (o[2] && done_at < 0) done_at = k;
    end
    check_int($sformatf("dut%0d w=%h done_cycle", which, w), done_at, exp_done);
  endtask

  task automatic run_abort(input int which, input int hold, input logic [7:0] w, input int ab_k);
    send(which, w);
    for (int k = 1; k <= ab_k; k++) begin
      @(negedge clk);
      check($sformatf("dut%0d abort w=%h cyc%0d", which, w, k), get_out(which),
            exp_out(w, hold, k));
    end
    set_in(which, 1'b0, ~w, 1'b1);
    @(posedge clk);
    #1 set_in(which, 1'b0, ~w, 1'b0);
    for (int k = ab_k + 1; k <= ab_k + 8; k++) begin
      @(negedge clk);
      check($sformatf("dut%0d after abort cyc%0d", which, k), get_out(which), IdleOut);
    end
  endtask

  initial begin
    vecs[0] = '{2, 2, 8'hA5, SkipMode ? 9 : 17};
    vecs[1] = '{2, 2, 8'hFF, 17};
    vecs[2] = '{2, 2, 8'h00, SkipMode ? 1 : 17};
    vecs[3] = '{2, 2, 8'h3C, SkipMode ? 9 : 17};
    vecs[4] = '{1, 1, 8'h55, SkipMode ? 5 : 9};
    vecs[5] = '{1, 1, 8'h82, SkipMode ? 3 : 9};
    vecs[6] = '{1, 1, 8'h00, SkipMode ? 1 : 9};
    vecs[7] = '{1, 1, 8'h81, SkipMode ? 3 : 9};

    rst = 1'b1;
    set_in(1, 1'b0, 8'h00, 1'b0);
    set_in(2, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check("reset dut1 held", get_out(1), IdleOut);
    check("reset dut2 held", get_out(2), IdleOut);
    rst = 1'b0;
    @(negedge clk);
    check("reset dut1 released", get_out(1), IdleOut);
    check("reset dut2 released", get_out(2), IdleOut);

    // abort while idle must be ignored
    set_in(1, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1 set_in(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("idle abort ignored", get_out(1), IdleOut);

    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].which, vecs[v].hold, vecs[v].data, vecs[v].done_cyc);
    end

    // in_valid held high: FF then 01, second accepted on the first IDLE edge
    begin
      int done_at;
      int len2;
      done_at = -1;
      @(negedge clk);
      set_in(2, 1'b1, 8'hFF, 1'b0);
      @(posedge clk);
      #1 set_in(2, 1'b1, 8'h01, 1'b0);
      for (int k = 1; k <= n_vis(8'hFF) * 2 + 2; k++) begin
        @(negedge clk);
        check($sformatf("b2b first cyc%0d", k), get_out(2), exp_out(8'hFF, 2, k));
      end
      @(posedge clk);
      #1 set_in(2, 1'b0, 8'hFE, 1'b0);
      len2 = n_vis(8'h01) * 2 + 2;
      for (int k = 1; k <= len2; k++) begin
        @(negedge clk);
        check($sformatf("b2b second cyc%0d", k), get_out(2), exp_out(8'h01, 2, k));
        if (bus2.done && done_at < 0) done_at = k;
      end
      check_int("b2b second done_cycle", done_at, SkipMode ? 3 : 17);
    end

    // abort during channel 3 of FF (HOLD=2: cycle 7)
    run_abort(2, 2, 8'hFF, 7);
    // abort on the final hold cycle of the last channel beats done (HOLD=1)
    run_abort(1, 1, 8'h55, n_vis(8'h55));

    // asynchronous reset during channel 5 (HOLD=2: cycle 11)
    send(2, 8'hA5);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check($sformatf("pre-reset cyc%0d", k), get_out(2), exp_out(8'hA5, 2, k));
    end
    #2 rst = 1'b1;
    #1 check("async reset immediate", get_out(2), IdleOut);
    @(negedge clk);
    rst = 1'b0;
    run_txn(2, 2, 8'hA5, SkipMode ? 9 : 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
